// File: rtl/cart_bus_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cart_bus_sequencer: cartridge header bus master (setup/strobe/hold       |
// | cycles, SRAM chip-select decode, data tristate, cartridge reset pin).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cart_bus_sequencer #(
   parameter int unsigned             ADDR_W     = 16,
   parameter int unsigned             DATA_W     = 8,
   parameter int unsigned             SETUP_CYC  = 1,
   parameter int unsigned             STROBE_CYC = 4,
   parameter int unsigned             HOLD_CYC   = 1,
   parameter int unsigned             RST_CYC    = 16,
   parameter logic [ADDR_W-1:0]       SRAM_LO    = 16'hA000,
   parameter logic [ADDR_W-1:0]       SRAM_HI    = 16'hBFFF
) (
   input  logic              clock,
   input  logic              reset_l,
   input  logic              soft_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] hdr_addr,
   output logic              hdr_rd_l,
   output logic              hdr_wr_l,
   output logic              hdr_cs_sram_l,
   output logic              hdr_rst_l,
   output logic [DATA_W-1:0] hdr_data_out,
   output logic              hdr_data_oe,
   input  logic [DATA_W-1:0] hdr_data_in
);

   localparam int unsigned c_MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned c_MAX_B   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
   localparam int unsigned c_MAX_CYC = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
   localparam int unsigned c_CNT_W   = $clog2(c_MAX_CYC) + 1;

   localparam logic [c_CNT_W-1:0] c_SETUP_LAST  = c_CNT_W'(SETUP_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_STROBE_LAST = c_CNT_W'(STROBE_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYC - 1);

   typedef enum logic [2:0] {
      ST_RST_SEQ = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_HOLD    = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_write;
   logic                r_soft_pend;
   logic [DATA_W-1:0]   r_cap;

   logic w_hs;
   logic w_sram;

   assign w_hs   = req_valid && req_ready;
   assign w_sram = (req_addr >= SRAM_LO) && (req_addr <= SRAM_HI);

   // r_cnt counts elapsed cycles of the current phase; cleared on every phase entry.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         r_state       <= ST_RST_SEQ;
         r_cnt         <= '0;
         r_write       <= 1'b0;
         r_soft_pend   <= 1'b0;
         r_cap         <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         busy          <= 1'b1;
         hdr_addr      <= '0;
         hdr_rd_l      <= 1'b1;
         hdr_wr_l      <= 1'b1;
         hdr_cs_sram_l <= 1'b1;
         hdr_rst_l     <= 1'b0;
         hdr_data_out  <= '0;
         hdr_data_oe   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            ST_RST_SEQ: begin
               if (soft_rst) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_RST_LAST) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  hdr_rst_l <= 1'b1;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_hs) begin
                  // A soft reset coinciding with an accepted request waits for it to finish.
                  r_state       <= ST_SETUP;
                  r_cnt         <= '0;
                  r_write       <= req_write;
                  r_soft_pend   <= soft_rst;
                  req_ready     <= 1'b0;
                  busy          <= 1'b1;
                  hdr_addr      <= req_addr;
                  hdr_cs_sram_l <= !w_sram;
                  hdr_data_oe   <= req_write;
                  if (req_write) begin
                     hdr_data_out <= req_wdata;
                  end
               end else if (soft_rst) begin
                  r_state   <= ST_RST_SEQ;
                  r_cnt     <= '0;
                  hdr_rst_l <= 1'b0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (soft_rst) begin
                  r_soft_pend <= 1'b1;
               end
               if (r_cnt == c_SETUP_LAST) begin
                  r_state <= ST_STROBE;
                  r_cnt   <= '0;
                  if (r_write) begin
                     hdr_wr_l <= 1'b0;
                  end else begin
                     hdr_rd_l <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STROBE: begin
               if (soft_rst) begin
                  r_soft_pend <= 1'b1;
               end
               if (r_cnt == c_STROBE_LAST) begin
                  r_state  <= ST_HOLD;
                  r_cnt    <= '0;
                  hdr_rd_l <= 1'b1;
                  hdr_wr_l <= 1'b1;
                  if (!r_write) begin
                     r_cap <= hdr_data_in;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (r_cnt == c_HOLD_LAST) begin
                  r_cnt         <= '0;
                  r_soft_pend   <= 1'b0;
                  hdr_cs_sram_l <= 1'b1;
                  hdr_data_oe   <= 1'b0;
                  if (!r_write) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= r_cap;
                  end
                  if (r_soft_pend || soft_rst) begin
                     r_state   <= ST_RST_SEQ;
                     hdr_rst_l <= 1'b0;
                  end else begin
                     r_state   <= ST_IDLE;
                     req_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end else begin
                  if (soft_rst) begin
                     r_soft_pend <= 1'b1;
                  end
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_RST_SEQ;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
